mul_shift_add: RTL and testbench
================================

Name: mul_shift_add

Overview:
- Iterative radix-2 shift-add multiplier for the execute stage, beside the ALU adder path.
- Consumes one WIDTH-bit add (with carry-out) per cycle. Produces a 2*WIDTH-bit product after a fixed number of cycles.
- Uses a start/busy/done handshake, so the control unit stalls the pipeline while busy_o=1.

Parameters:
- WIDTH, 32, operand width in bits. Legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; not overridden.

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request a multiply; sampled only when busy_o=0
- a_i  in  WIDTH  multiplicand
- b_i  in  WIDTH  multiplier
- busy_o  out  1  iteration in progress
- done_o  out  1  one-cycle pulse: result_o just updated
- result_o  out  2*WIDTH  product; held until the next accepted start
- signed_i  in  1  present only with MUL_SIGNED_EN; 1 = operands are two's complement

Behaviour:
- Reset: reset is synchronous and active-high on rst_i, with one clock clk_i.
  - On reset: state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal registers=0.
  - Reset asserted mid-operation aborts the operation. No done_o pulse follows.
- States:
  - IDLE: busy_o=0, done_o=0.
  - RUN: busy_o=1.
  - DONE: busy_o=0, done_o=1.
- Transitions:
  - IDLE --start_i--> RUN.
  - RUN --(counter==WIDTH-1)--> DONE.
  - DONE --start_i--> RUN; otherwise DONE --> IDLE.
- Accept: on a clock edge with start_i=1 and busy_o=0:
  - latch M=a_i, Q=b_i, P_hi=0, carry=0, counter=0.
  - a_i/b_i are don't-care after the accept edge.
- RUN iteration, one per cycle:
  - sum = P_hi + (Q[0] ? M : 0), a WIDTH+1-bit result with carry-out c.
  - {c, P_hi, Q} is then shifted right by 1 into {P_hi, Q}.
  - counter increments by 1.
- Final cycle: on the edge leaving the last RUN cycle, result_o <= {P_hi, Q} after the final shift, and the state moves to DONE.
- Latency:
  - start_i accepted at edge 0.
  - busy_o=1 for exactly WIDTH cycles.
  - done_o=1 in the cycle after that, i.e. WIDTH+1 cycles after the accept edge.
  - done_o lasts exactly 1 cycle.
- start_i while busy_o=1 is ignored and not queued.
- start_i during DONE is accepted; back-to-back operations have no idle bubble.
- result_o changes only on the final-iteration edge. It stays stable during the next operation's RUN until that operation completes.
- Operands of 0 still take the full WIDTH cycles; there is no early termination.
- Unsigned arithmetic only (no macro): the product is exact. Max value (2^WIDTH-1)^2 fits in 2*WIDTH bits, with no overflow flag.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Port signed_i exists and is latched at accept.
  - If signed_i=1, M and Q are loaded with the absolute values of a_i and b_i, and sign = a_i[MSB]^b_i[MSB] is latched.
  - On the final edge, result_o receives the two's-complement negation of the product when sign=1.
  - Latency is unchanged (WIDTH+1).
  - Most-negative × most-negative gives +2^(2*WIDTH-2), which is representable.
  - signed_i=0 behaves exactly as unsigned.
- Not defined: no signed_i port; unsigned only.
- Both builds have identical timing and handshake.

Test Plan (WIDTH=32):
- Reset, then idle: busy_o=0, done_o=0, result_o=0. Pulse start_i with a_i=7, b_i=6: busy_o high for 32 cycles; done_o high at cycle 33 for 1 cycle; result_o=42.
- a_i=b_i=0xFFFFFFFF: result_o=0xFFFFFFFE00000001.
- Back-to-back: start_i held high, a_i=3/b_i=5, then a_i=0x10000/b_i=0x10000 applied at the DONE cycle:
  - results 15, then 0x100000000.
  - no idle cycle between operations.
  - start_i during RUN is ignored.
- Reset mid-operation: rst_i=1 at cycle 10 of RUN. Next cycle: busy_o=0, result_o=0, and no done_o follows.
- MUL_SIGNED_EN, signed_i=1:
  - a_i=-3 (0xFFFFFFFD), b_i=5 gives result_o=0xFFFFFFFFFFFFFFF1 (-15).
  - a_i=b_i=0x80000000 gives result_o=0x4000000000000000.
  - signed_i=0 with a_i=0xFFFFFFFD, b_i=5 gives 0x4FFFFFFF1.
- Operand hold: change a_i/b_i every cycle during RUN. result_o still matches the operands latched at accept.

Source files
------------

// File: rtl/mul_shift_add.sv
// Iterative radix-2 shift-add multiplier with a start/busy/done handshake.
// Define MUL_SIGNED_EN to add the signed_i port and two's-complement operand support.
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
`ifdef MUL_SIGNED_EN
    input  logic               signed_i,
`endif
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   m_r, m_s;
    logic [WIDTH-1:0]   q_r, q_s;
    logic [WIDTH-1:0]   p_hi_r, p_hi_s;
    logic               sign_r, sign_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [2*WIDTH-1:0] result_r, result_s;

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] product_s;
    logic [2*WIDTH-1:0] final_s;
    logic [WIDTH-1:0]   m_load_s;
    logic [WIDTH-1:0]   q_load_s;
    logic               sign_load_s;

`ifdef MUL_SIGNED_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic en);
        if (en && x[WIDTH-1]) begin
            magnitude = ~x + WIDTH'(1);
        end else begin
            magnitude = x;
        end
    endfunction

    // Operand conditioning: magnitudes plus the product sign for signed requests.
    always_comb begin
        m_load_s    = magnitude(a_i, signed_i);
        q_load_s    = magnitude(b_i, signed_i);
        sign_load_s = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end
`else
    // Operand conditioning: unsigned operands load unchanged.
    always_comb begin
        m_load_s    = a_i;
        q_load_s    = b_i;
        sign_load_s = 1'b0;
    end
`endif

    // One add-and-shift step; product_s is {c, P_hi, Q} shifted right by one.
    always_comb begin
        sum_s     = {1'b0, p_hi_r} + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
        product_s = {sum_s, q_r[WIDTH-1:1]};
        if (sign_r) begin
            final_s = ~product_s + (2*WIDTH)'(1);
        end else begin
            final_s = product_s;
        end
    end

    // Next-state and datapath update; start is only honoured while not busy.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        m_s      = m_r;
        q_s      = q_r;
        p_hi_s   = p_hi_r;
        sign_s   = sign_r;
        result_s = result_r;
        case (state_r)
            ST_RUN: begin
                p_hi_s = sum_s[WIDTH:1];
                q_s    = {sum_s[0], q_r[WIDTH-1:1]};
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_s  = ST_DONE;
                    result_s = final_s;
                end else begin
                    state_s  = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_s = ST_RUN;
                    m_s     = m_load_s;
                    q_s     = q_load_s;
                    p_hi_s  = {WIDTH{1'b0}};
                    sign_s  = sign_load_s;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            m_r      <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            p_hi_r   <= {WIDTH{1'b0}};
            sign_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            m_r      <= m_s;
            q_r      <= q_s;
            p_hi_r   <= p_hi_s;
            sign_r   <= sign_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            result_r <= result_s;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: directed corners plus randomized operations
// compared against a plain-arithmetic product model.
module tb_mul_shift_add;
    localparam int W = 32;

    logic           clk_i;
    logic           rst_i;
    logic           start_i;
`ifdef MUL_SIGNED_EN
    logic           signed_i;
`endif
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] result_o;

    int             n_checks;
    int             n_fail;
    logic [2*W-1:0] exp_result;

    mul_shift_add #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
`ifdef MUL_SIGNED_EN
        .signed_i (signed_i),
`endif
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (sg) begin
            sa = $signed({{W{a[W-1]}}, a});
            sb = $signed({{W{b[W-1]}}, b});
            ref_mul = sa * sb;
        end else begin
            ref_mul = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    endfunction

    // Called just after a negedge in an IDLE or DONE cycle; returns in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input bit hold_start);
        logic [2*W-1:0] exp;
        exp     = ref_mul(a, b, sg);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
`ifdef MUL_SIGNED_EN
        signed_i = sg;
`endif
        @(negedge clk_i);
        for (int k = 0; k < W; k++) begin
            check_eq("run_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd1);
            check_eq("run_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);
            check_eq("run_result_held", result_o, exp_result);
            a_i     = W'($urandom);
            b_i     = W'($urandom);
            start_i = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef MUL_SIGNED_EN
            signed_i = 1'($urandom_range(0, 1));
`endif
            @(negedge clk_i);
        end
        exp_result = exp;
        check_eq("done_pulse", {{(2*W-1){1'b0}}, done_o}, 64'd1);
        check_eq("done_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd0);
        check_eq("done_result", result_o, exp_result);
        start_i = 1'b0;
    endtask

    initial begin
        logic   seen_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic   rsg;
        n_checks   = 0;
        n_fail     = 0;
        exp_result = '0;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        a_i        = '0;
        b_i        = '0;
`ifdef MUL_SIGNED_EN
        signed_i   = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        check_eq("reset_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd0);
        check_eq("reset_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);
        check_eq("reset_result", result_o, 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd0);
        check_eq("idle_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);

        run_op(32'd7, 32'd6, 1'b0, 1'b0);
        check_eq("r_7x6", result_o, 64'd42);
        @(negedge clk_i);
        check_eq("done_one_cycle", {{(2*W-1){1'b0}}, done_o}, 64'd0);
        check_eq("after_done_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd0);
        check_eq("after_done_result", result_o, 64'd42);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_eq("r_max", result_o, 64'hFFFF_FFFE_0000_0001);

        // Back-to-back with start held high throughout.
        run_op(32'd3, 32'd5, 1'b0, 1'b1);
        check_eq("r_b2b_first", result_o, 64'd15);
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        check_eq("r_b2b_second", result_o, 64'h0000_0001_0000_0000);
        @(negedge clk_i);
        check_eq("b2b_idle_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);

        run_op(32'd0, 32'd0, 1'b0, 1'b0);
        check_eq("r_zero", result_o, 64'd0);

        // Abort mid-operation with reset in the tenth RUN cycle.
        start_i = 1'b1;
        a_i     = 32'd1234;
        b_i     = 32'd5678;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check_eq("pre_abort_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_result = '0;
        check_eq("abort_busy", {{(2*W-1){1'b0}}, busy_o}, 64'd0);
        check_eq("abort_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);
        check_eq("abort_result", result_o, 64'd0);
        seen_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk_i);
            if (done_o) seen_done = 1'b1;
        end
        check_eq("abort_no_done", {{(2*W-1){1'b0}}, seen_done}, 64'd0);

`ifdef MUL_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        check_eq("s_neg3x5", result_o, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        check_eq("s_minxmin", result_o, 64'h4000_0000_0000_0000);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        check_eq("u_fffffffdx5", result_o, 64'h0000_0004_FFFF_FFF1);
`endif

        for (int i = 0; i < 24; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 6 == 1) ra = 32'h8000_0000;
            if (i % 6 == 4) rb = 32'hFFFF_FFFF;
            rsg = 1'b0;
`ifdef MUL_SIGNED_EN
            rsg = 1'($urandom_range(0, 1));
`endif
            run_op(ra, rb, rsg, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk_i);
                check_eq("rand_gap_done", {{(2*W-1){1'b0}}, done_o}, 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
